// File: rtl/serial_bus_arbiter.sv
// Two-endpoint serial bus arbiter: grants one frame of FRAME_BITS bits at a time,
// counts good frames up to NFRAMES. Define ROUND_ROBIN_EN for alternating arbitration.
module serial_bus_arbiter #(
    parameter int FRAME_BITS = 13,
    parameter int NFRAMES    = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       updown,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       sen_obs,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rx_strobe,
    output logic [3:0] bit_cnt,
    output logic [4:0] frame_cnt,
    output logic       xfer_done,
    output logic       all_done,
    output logic       bus_err
);

    // state | meaning
    // IDLE  | waiting for a request, arbitration decision
    // GRANT | grant asserted, bus setup cycle, bit_cnt=0
    // SHIFT | one data bit per cycle, rx_strobe high
    // GAP   | one bus-idle turnaround cycle
    // DONE  | session complete, requests ignored until reset
    typedef enum logic [2:0] {IDLE, GRANT, SHIFT, GAP, DONE} state_t;

    localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [4:0] FRAME_MAX = 5'(NFRAMES);

    state_t state;
    logic   pick_b;

`ifdef ROUND_ROBIN_EN
    logic rr_ptr;  // 1: B is preferred at the next contested decision

    always_comb begin
        pick_b = req_b && (!req_a || rr_ptr);
    end
`else
    always_comb begin
        pick_b = req_b && (!req_a || updown);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rx_strobe <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            xfer_done <= 1'b0;
            all_done  <= 1'b0;
            bus_err   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            xfer_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state   <= GRANT;
                        gnt_a   <= !pick_b;
                        gnt_b   <= pick_b;
                        bit_cnt <= '0;
`ifdef ROUND_ROBIN_EN
                        rr_ptr  <= !pick_b;
`endif
                    end
                end
                GRANT: begin
                    state     <= SHIFT;
                    rx_strobe <= 1'b1;
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    // An undriven bus aborts the frame even on its last bit
                    if (sen_obs) begin
                        state     <= GAP;
                        bus_err   <= 1'b1;
                        gnt_a     <= 1'b0;
                        gnt_b     <= 1'b0;
                        rx_strobe <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (bit_cnt == LAST_BIT) begin
                        state     <= GAP;
                        gnt_a     <= 1'b0;
                        gnt_b     <= 1'b0;
                        rx_strobe <= 1'b0;
                        bit_cnt   <= '0;
                        xfer_done <= 1'b1;
                        if (frame_cnt != FRAME_MAX)
                            frame_cnt <= frame_cnt + 5'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (frame_cnt == FRAME_MAX) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Randomized self-checking bench for serial_bus_arbiter against a frame-offset
// reference model; honours ROUND_ROBIN_EN like the design.
module tb_serial_bus_arbiter;

    localparam int FB = 13;
    localparam int NF = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       updown = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       sen_obs = 1'b0;
    logic       gnt_a, gnt_b, rx_strobe, xfer_done, all_done, bus_err;
    logic [3:0] bit_cnt;
    logic [4:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: frame position as an offset from grant cycle
    bit m_done, m_gap, m_in, m_who, m_ptr, m_berr, m_xfer;
    int m_k, m_fcnt;

    serial_bus_arbiter #(.FRAME_BITS(FB), .NFRAMES(NF)) dut (
        .clk(clk), .rst(rst), .updown(updown), .req_a(req_a), .req_b(req_b),
        .sen_obs(sen_obs), .gnt_a(gnt_a), .gnt_b(gnt_b), .rx_strobe(rx_strobe),
        .bit_cnt(bit_cnt), .frame_cnt(frame_cnt), .xfer_done(xfer_done),
        .all_done(all_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_done = 0; m_gap = 0; m_in = 0; m_who = 0; m_ptr = 0;
        m_berr = 0; m_xfer = 0; m_k = 0; m_fcnt = 0;
    endtask

    task automatic model_step();
        bit both;
        m_xfer = 0;
        if (m_done) begin
        end else if (m_gap) begin
            m_gap = 0;
            if (m_fcnt == NF) m_done = 1;
        end else if (m_in) begin
            if (m_k >= 1 && sen_obs) begin
                m_berr = 1; m_in = 0; m_gap = 1;
            end else if (m_k == FB) begin
                m_in = 0; m_gap = 1; m_xfer = 1; m_fcnt++;
            end else begin
                m_k++;
            end
        end else if (req_a || req_b) begin
            both = req_a && req_b;
`ifdef ROUND_ROBIN_EN
            m_who = both ? m_ptr : req_b;
`else
            m_who = both ? updown : req_b;
`endif
            m_ptr = !m_who;
            m_in = 1;
            m_k = 0;
        end
    endtask

    task automatic compare_all();
        check("gnt_a", 32'(gnt_a), 32'(m_in && !m_who));
        check("gnt_b", 32'(gnt_b), 32'(m_in && m_who));
        check("rx_strobe", 32'(rx_strobe), 32'(m_in && m_k >= 1));
        check("bit_cnt", 32'(bit_cnt), (m_in && m_k >= 1) ? 32'(m_k - 1) : 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        check("xfer_done", 32'(xfer_done), 32'(m_xfer));
        check("all_done", 32'(all_done), 32'(m_done));
        check("bus_err", 32'(bus_err), 32'(m_berr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_step();
        compare_all();
    endtask

    initial begin
        int n;
        int gnt_seen;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // single requester A, full frame
        req_a = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        req_a = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // asynchronous reset while bit 7 is on the bus
        req_b = 1'b1;
        n = 0;
        while (!(m_in && m_k == 8) && n < 100) begin tick(); n++; end
        check("reach_bit7", 32'(m_in && m_k == 8), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 18; i++) tick();

        // both requesting, updown=1, three frames
        req_a = 1'b1; req_b = 1'b1; updown = 1'b1;
        for (int i = 0; i < 45; i++) tick();
        req_b = 1'b0; updown = 1'b0;

        // undriven bus at bit_cnt 5
        n = 0;
        while (!(m_in && m_k == 6) && n < 100) begin tick(); n++; end
        check("reach_bit5", 32'(m_in && m_k == 6), 32'd1);
        sen_obs = 1'b1;
        tick();
        sen_obs = 1'b0;
        check("err_gnt_low", 32'(gnt_a | gnt_b), 32'd0);
        check("err_flag", 32'(bus_err), 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // random traffic with occasional bus faults
        for (int i = 0; i < 700 && !m_done; i++) begin
            req_a   = ($urandom_range(0, 3) != 0);
            req_b   = ($urandom_range(0, 3) != 0);
            updown  = $urandom_range(0, 1) != 0;
            sen_obs = ($urandom_range(0, 79) == 0);
            tick();
        end

        // run the session out
        sen_obs = 1'b0; req_a = 1'b1; req_b = 1'b0;
        n = 0;
        while (!m_done && n < 600) begin tick(); n++; end
        check("session_done", 32'(m_done), 32'd1);

        // requests in DONE must be ignored
        gnt_seen = 0;
        req_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_a || gnt_b) gnt_seen++;
        end
        check("done_no_grant", 32'(gnt_seen), 32'd0);
        check("final_all_done", 32'(all_done), 32'd1);
        check("final_frame_cnt", 32'(frame_cnt), 32'(NF));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
